// File: rtl/count_checker.sv
// Sequence monitor for an up-counter: locks after a seed plus two matches; flags skips/repeats. Outputs registered, one cycle after the sample.
// No backpressure: samples are consumed whenever en is high, and gaps with en low are not errors.
module count_checker #(
    parameter int WIDTH     = 3,
    parameter int ERR_LIMIT = 3,
    parameter int WRAP_W    = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic [WIDTH-1:0]  count_in,
    input  logic              clear,
    output logic              locked,
    output logic              error,
    output logic              fault,
    output logic [WRAP_W-1:0] wrap_cnt,
    output logic [3:0]        err_cnt
);

    typedef enum logic [1:0] {IDLE, SYNC, LOCKED, FAULT} state_t;

    state_t              r_state, w_state_nxt;
    logic [WIDTH-1:0]    r_exp, w_exp_nxt;
    logic                r_good, w_good_nxt;
    logic [3:0]          r_miss, w_miss_nxt;
    logic                r_error, w_error_nxt;
    logic [WRAP_W-1:0]   r_wrap, w_wrap_nxt;
    logic [3:0]          r_err, w_err_nxt;

    logic                w_match;
    logic [WIDTH-1:0]    w_inc;
    logic [3:0]          w_miss_inc;

    assign w_match    = (count_in == r_exp);
    assign w_inc      = count_in + 1'b1;
    assign w_miss_inc = r_miss + 4'd1;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
            r_exp   <= '0;
            r_good  <= 1'b0;
            r_miss  <= 4'd0;
            r_error <= 1'b0;
            r_wrap  <= '0;
            r_err   <= 4'd0;
        end else begin
            r_state <= w_state_nxt;
            r_exp   <= w_exp_nxt;
            r_good  <= w_good_nxt;
            r_miss  <= w_miss_nxt;
            r_error <= w_error_nxt;
            r_wrap  <= w_wrap_nxt;
            r_err   <= w_err_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_exp_nxt   = r_exp;
        w_good_nxt  = r_good;
        w_miss_nxt  = r_miss;
        w_error_nxt = 1'b0;
        w_wrap_nxt  = r_wrap;
        w_err_nxt   = r_err;

        if (clear) begin
            w_state_nxt = IDLE;
            w_exp_nxt   = '0;
            w_good_nxt  = 1'b0;
            w_miss_nxt  = 4'd0;
            w_wrap_nxt  = '0;
            w_err_nxt   = 4'd0;
        end else if (en) begin
            case (r_state)
                IDLE: begin
                    w_state_nxt = SYNC;
                    w_exp_nxt   = w_inc;
                    w_good_nxt  = 1'b0;
                end
                SYNC: begin
                    w_exp_nxt = w_inc;
                    if (w_match) begin
                        if (r_good) begin
                            w_state_nxt = LOCKED;
                            w_miss_nxt  = 4'd0;
                        end else begin
                            w_good_nxt = 1'b1;
                        end
                    end else begin
                        w_good_nxt = 1'b0;
                    end
                end
                LOCKED: begin
                    w_exp_nxt = w_inc;
                    if (w_match) begin
                        w_miss_nxt = 4'd0;
                        // only a matched zero is a genuine max-to-0 wrap
                        if (count_in == '0)
                            w_wrap_nxt = r_wrap + 1'b1;
                    end else begin
                        w_error_nxt = 1'b1;
                        w_miss_nxt  = w_miss_inc;
                        if (r_err != 4'd15)
                            w_err_nxt = r_err + 4'd1;
                        if (w_miss_inc == 4'(ERR_LIMIT))
                            w_state_nxt = FAULT;
                    end
                end
                default: ;
            endcase
        end
    end

    assign locked   = (r_state == LOCKED);
    assign fault    = (r_state == FAULT);
    assign error    = r_error;
    assign wrap_cnt = r_wrap;
    assign err_cnt  = r_err;

endmodule
